// File: rtl/siso_shift_reg.sv
// Serial-in serial-out delay line: each bit on d reappears on qout DEPTH clocks later,
// with qb always the complement of qout.
module siso_shift_reg #(
  parameter int   DEPTH     = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic qout,
  output logic qb
);

  logic [DEPTH-1:0] r_stage;

  // Bit 0 is nearest the input; DEPTH=1 gets its own branch so the chain slice never goes negative.
  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          r_stage <= {DEPTH{RESET_VAL}};
        end else begin
          r_stage <= d;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (rst) begin
          r_stage <= {DEPTH{RESET_VAL}};
        end else begin
          r_stage <= {r_stage[DEPTH-2:0], d};
        end
      end
    end
  endgenerate

  assign qout = r_stage[DEPTH-1];
  assign qb   = ~r_stage[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_reg.sv
// Bench for siso_shift_reg: four instances (various DEPTH/RESET_VAL) share one stream and
// are checked against a queue-based history of sampled bits.
module tb_siso_shift_reg;

  logic clk;
  logic rst;
  logic d;
  logic qout4, qb4;
  logic qout1, qb1;
  logic qout8, qb8;
  logic qout8r, qb8r;

  int compareCount;
  int mismatchCount;

  // Every bit sampled on a non-reset edge since the last reset, oldest first.
  bit history[$];

  siso_shift_reg #(.DEPTH(4), .RESET_VAL(1'b0)) dutDepth4 (
    .clk(clk), .rst(rst), .d(d), .qout(qout4), .qb(qb4));
  siso_shift_reg #(.DEPTH(1), .RESET_VAL(1'b0)) dutDepth1 (
    .clk(clk), .rst(rst), .d(d), .qout(qout1), .qb(qb1));
  siso_shift_reg #(.DEPTH(8), .RESET_VAL(1'b0)) dutDepth8 (
    .clk(clk), .rst(rst), .d(d), .qout(qout8), .qb(qb8));
  siso_shift_reg #(.DEPTH(8), .RESET_VAL(1'b1)) dutDepth8Set (
    .clk(clk), .rst(rst), .d(d), .qout(qout8r), .qb(qb8r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A bit sampled DEPTH edges ago is on qout; until that many bits exist the output is the reset value.
  function automatic logic expectedQ(input int depth, input logic resetVal);
    if (history.size() >= depth) return history[history.size() - depth];
    return resetVal;
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Noise on d early in the cycle must not matter; only the value at the edge counts.
  task automatic applyStimulus(input string phase, input logic rstVal, input logic dVal);
    logic e;
    @(negedge clk);
    d = 1'($urandom);
    #2;
    rst = rstVal;
    d   = dVal;
    @(posedge clk);
    if (rstVal) history.delete();
    else history.push_back(dVal);
    #1;
    e = expectedQ(4, 1'b0);
    checkOutput({phase, " d4 qout"}, qout4, e);
    checkOutput({phase, " d4 qb"}, qb4, ~e);
    e = expectedQ(1, 1'b0);
    checkOutput({phase, " d1 qout"}, qout1, e);
    checkOutput({phase, " d1 qb"}, qb1, ~e);
    e = expectedQ(8, 1'b0);
    checkOutput({phase, " d8 qout"}, qout8, e);
    checkOutput({phase, " d8 qb"}, qb8, ~e);
    e = expectedQ(8, 1'b1);
    checkOutput({phase, " d8set qout"}, qout8r, e);
    checkOutput({phase, " d8set qb"}, qb8r, ~e);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    d   = 1'b1;

    for (int i = 0; i < 2; i++) applyStimulus("reset", 1'b1, 1'b1);

    applyStimulus("single", 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus("single", 1'b0, 1'b0);

    applyStimulus("altReset", 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus("alternate", 1'b0, (i % 2 == 0));
    for (int i = 0; i < 8; i++) applyStimulus("altDrain", 1'b0, 1'b0);

    applyStimulus("midReset", 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("ones", 1'b0, 1'b1);
    applyStimulus("midReset", 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus("onesResume", 1'b0, 1'b1);

    applyStimulus("randReset", 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus("random64", 1'b0, 1'($urandom));

    for (int i = 0; i < 150; i++)
      applyStimulus("randMix", ($urandom_range(0, 15) == 0), 1'($urandom));

    for (int i = 0; i < 3; i++) applyStimulus("holdReset", 1'b1, 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
